mem_master: RTL and testbench

- CPU-side initiator for the single-port data memory bus.
- Accepts one load/store request at a time from the MEM pipeline stage and drives the memory's address, rd/wr strobes and shared data bus.
- Waits for the memory's registered ready before completing each bus phase.
- Supports byte, halfword and word accesses; sub-word stores are done as read-modify-write.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_master_if.sv | 30 +++
 rtl/lane_unit.sv | 47 ++++
 rtl/mem_master.sv | 189 ++++++++++++++++++
 tb/tb_mem_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the data-memory bus initiator.
//   Access size encodings, FSM state encoding, default timeout and a
//   request legality helper used by mem_master.
//   Optional feature macro (consumed by mem_master): MEM_TIMEOUT_EN.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_TURN = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'd3) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// mem_master_if -- request/response handshake plus memory address/strobe
//   signals between the MEM stage, mem_master and the data memory.
//   The shared data bus stays a plain inout on mem_master.
//   master modport: mem_master side. slave modport: requester + memory side.
interface mem_master_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ready;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rd, mem_wr
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rd, mem_wr
  );
endinterface

// File: rtl/lane_unit.sv
// lane_unit -- combinational little-endian lane logic.
//   i_word    : word read from memory
//   i_addr_lo : byte offset within the word
//   i_size    : access size (mem_pkg SZ_*)
//   i_signed  : sign-extend sub-word loads
//   i_wdata   : right-aligned store data
//   o_load    : extracted and extended load value
//   o_merged  : i_word with the store lane replaced by i_wdata
module lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_master.sv
// mem_master -- CPU-side initiator for the single-port data memory bus.
//   One load/store at a time; sub-word stores are read-modify-write.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : mem_master_if.master (request/response + mem addr/strobes/ready)
//   mem_data : shared data bus, driven with the write buffer only while mem_wr=1
//   Optional: define MEM_TIMEOUT_EN to abort RD/WR after TIMEOUT_CYCLES
//   cycles without mem_ready.
//
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request
//   RD    | mem_rd=1, waiting for mem_ready, then capture mem_data
//   TURN  | one quiet bus cycle between the read and write of an RMW
//   WR    | mem_wr=1, mem_data driven, waiting for mem_ready
//   RESP  | resp_valid pulse, then back to IDLE
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_master_if.master    bus,
  inout  wire [31:0]      mem_data
);

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_wdata;
  logic [31:0]       r_wbuf;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]        r_wait;
`endif

  logic [31:0] w_load;
  logic [31:0] w_merged;

  lane_unit u_lane (
    .i_word    (mem_data),
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  // r_mem_wr is async-reset, so the bus is released the instant rst_n falls.
  assign mem_data = r_mem_wr ? r_wbuf : 'z;

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_wdata      <= '0;
      r_wbuf       <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_wait       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_addr_lo   <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait      <= '0;
`endif
            if (is_bad_req(bus.req_size, bus.req_addr[1:0])) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= ST_RESP;
            end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              r_wbuf     <= bus.req_wdata;
              r_mem_wr   <= 1'b1;
              r_state    <= ST_WR;
            end else begin
              // Loads and sub-word stores both start with a read.
              r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              r_mem_rd   <= 1'b1;
              r_state    <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (bus.mem_ready) begin
            r_mem_rd <= 1'b0;
            if (r_we) begin
              r_wbuf  <= w_merged;
              r_state <= ST_TURN;
            end else begin
              r_resp_rdata <= w_load;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_wait == 8'(TIMEOUT_CYCLES - 1)) begin
            r_mem_rd     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end

        ST_TURN: begin
          r_mem_wr <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          r_wait   <= '0;
`endif
          r_state  <= ST_WR;
        end

        ST_WR: begin
          if (bus.mem_ready) begin
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_wait == 8'(TIMEOUT_CYCLES - 1)) begin
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end

        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master -- directed bench for mem_master against a 1-cycle-ready
//   memory model (64 words). Build with +define+MEM_TIMEOUT_EN to also
//   cover the timeout path.
module tb_mem_master;
  import mem_pkg::*;

  logic clk;
  logic rst_n;
  wire  [31:0] mem_data;

  mem_master_if #(.ADDR_W(32)) bus ();

  mem_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        stall;
  logic        probe_en;
  logic [31:0] probe_val;
  int          cyc;
  int          rd_total;
  int          wr_total;
  int          last_rd_cyc;
  int          wr_rise_cyc;
  logic        prev_wr;

  assign mem_data = bus.mem_rd ? mem[bus.mem_addr[7:2]] : (probe_en ? probe_val : 32'hzzzz_zzzz);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready <= 1'b0;
      prev_wr       <= 1'b0;
    end else begin
      bus.mem_ready <= (bus.mem_rd | bus.mem_wr) & ~stall;
      if (bus.mem_wr && !bus.mem_ready) mem[bus.mem_addr[7:2]] <= mem_data;
      prev_wr <= bus.mem_wr;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd) begin
      rd_total    <= rd_total + 1;
      last_rd_cyc <= cyc;
    end
    if (bus.mem_wr) wr_total <= wr_total + 1;
    if (bus.mem_wr && !prev_wr) wr_rise_cyc <= cyc;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rd_n, output int wr_n);
    int w;
    int rd0;
    int wr0;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    rd0 = rd_total;
    wr0 = wr_total;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
    end while (!bus.resp_valid && lat < 64);
    if (!bus.resp_valid) chk("resp_wait", 32'd0, 32'd1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    rd_n  = rd_total - rd0;
    wr_n  = wr_total - wr0;
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          rd_n;
  int          wr_n;
  logic [31:0] last_load;
  logic        seen;

  initial begin
    cyc = 0; rd_total = 0; wr_total = 0; last_rd_cyc = 0; wr_rise_cyc = 0;
    stall = 1'b0; probe_en = 1'b0; probe_val = 32'h5A5A_5A5A;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'd0, bus.resp_err}, 32'd0);
    chk("rst_strobes",    {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr",   bus.mem_addr, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;

    // Word store then word load
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, rdata, err, lat, rd_n, wr_n);
    chk("wst_lat", lat, 3);
    chk("wst_err", {31'd0, err}, 32'd0);
    chk("wst_mem", mem[4], 32'hDEAD_BEEF);
    chk("wst_no_rd", rd_n, 0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("wld_data", rdata, 32'hDEAD_BEEF);
    chk("wld_err", {31'd0, err}, 32'd0);
    chk("wld_lat", lat, 3);
    chk("wld_no_wr", wr_n, 0);

    // Sub-word loads from 0x8001_7F80 @0x20
    do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h8001_7F80, rdata, err, lat, rd_n, wr_n);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("ld_sb20", rdata, 32'hFFFF_FF80);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("ld_ub21", rdata, 32'h0000_007F);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("ld_sh22", rdata, 32'hFFFF_8001);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("ld_uh20", rdata, 32'h0000_7F80);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("ld_ub23", rdata, 32'h0000_0080);
    chk("ld_lat", lat, 3);
    last_load = 32'h0000_0080;

    // Read-modify-write stores on 0x11223344 @0x30
    do_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h1122_3344, rdata, err, lat, rd_n, wr_n);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'hFFFF_FFAB, rdata, err, lat, rd_n, wr_n);
    chk("sb_mem", mem[12], 32'h1122_AB44);
    chk("sb_lat", lat, 6);
    chk("sb_err", {31'd0, err}, 32'd0);
    chk("sb_turn_gap", wr_rise_cyc - last_rd_cyc, 2);
    chk("sb_rdata_held", rdata, last_load);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h1234_CAFE, rdata, err, lat, rd_n, wr_n);
    chk("sh_mem", mem[12], 32'hCAFE_AB44);
    chk("sh_lat", lat, 6);

    // Error requests: no bus activity, rdata unchanged
    do_req(1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("e_half_err", {31'd0, err}, 32'd1);
    chk("e_half_lat", lat, 1);
    chk("e_half_bus", rd_n + wr_n, 0);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h42, 32'h5555_5555, rdata, err, lat, rd_n, wr_n);
    chk("e_word_err", {31'd0, err}, 32'd1);
    chk("e_word_lat", lat, 1);
    chk("e_word_bus", rd_n + wr_n, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("e_size3_err", {31'd0, err}, 32'd1);
    chk("e_size3_lat", lat, 1);
    chk("e_size3_bus", rd_n + wr_n, 0);
    chk("e_rdata_held", rdata, last_load);

    // Reset during WR
    @(negedge clk);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = SZ_WORD; bus.req_signed = 1'b0;
    bus.req_addr = 32'h50; bus.req_wdata = 32'h1234_5678; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rw_wr_active", {31'd0, bus.mem_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rw_wr_drop", {31'd0, bus.mem_wr}, 32'd0);
    probe_en = 1'b1;
    #1 chk("rw_bus_released", mem_data, 32'h5A5A_5A5A);
    probe_en = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    chk("rw_no_resp", {31'd0, seen}, 32'd0);
    chk("rw_ready", {31'd0, bus.req_ready}, 32'd1);

    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("post_rst_ld", rdata, 32'hDEAD_BEEF);

`ifdef MEM_TIMEOUT_EN
    stall = 1'b1;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rdata, err, lat, rd_n, wr_n);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_lat", lat, 17);
    chk("to_rd_drop", {31'd0, bus.mem_rd}, 32'd0);
    stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
